// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU's divide group.
//   div_op_t    : DIV / DIVU / REM / REMU encoding; equals alu_op[1:0] of the
//                 ALU's div group. Bit 1 selects the remainder, bit 0 selects
//                 unsigned.
//   div_state_t : state encoding of the sequential divider.
//   Helpers decode the op into "signed?" and "wants remainder?".
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    Div  = 2'b00,
    Divu = 2'b01,
    Rem  = 2'b10,
    Remu = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    DivIdle,
    DivCalc,
    DivFix,
    DivDone
  } div_state_t;

  function automatic logic div_op_is_signed(div_op_t op);
    return (op == Div) || (op == Rem);
  endfunction

  function automatic logic div_op_is_rem(div_op_t op);
    return (op == Rem) || (op == Remu);
  endfunction

endpackage

// File: rtl/sklansky_adder.sv
// ---------------------------------------------------------------------------
// sklansky_adder
//   Parallel-prefix (Sklansky) adder of arbitrary width.
//   Ports:
//     a, b   in   INPUT_SIZE  addends
//     c_in   in   1           carry into bit 0
//     sum    out  INPUT_SIZE  a + b + c_in (modulo 2^INPUT_SIZE)
//     c_out  out  1           carry out of the top bit
//   The carry-in is folded into the bit-0 generate term, so the prefix tree
//   directly yields the carry out of every bit position.
// ---------------------------------------------------------------------------
module sklansky_adder #(
  parameter int INPUT_SIZE = 65
) (
  input  logic [INPUT_SIZE-1:0] a,
  input  logic [INPUT_SIZE-1:0] b,
  input  logic                  c_in,
  output logic [INPUT_SIZE-1:0] sum,
  output logic                  c_out
);

  localparam int LEVELS = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  // Group generate/propagate after each prefix level; level 0 is per-bit.
  logic [INPUT_SIZE-1:0] g_lvl [LEVELS+1];
  logic [INPUT_SIZE-1:0] p_lvl [LEVELS+1];

  always_comb begin
    int j;
    j        = 0;
    g_lvl[0] = a & b;
    p_lvl[0] = a ^ b;
    g_lvl[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & c_in);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (((i >> l) & 1) == 1) begin
          // Combine with the last node of the preceding 2^l-wide block.
          j = ((i >> l) << l) - 1;
          g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][j]);
          p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][j];
        end else begin
          g_lvl[l+1][i] = g_lvl[l][i];
          p_lvl[l+1][i] = p_lvl[l][i];
        end
      end
    end
  end

  assign sum   = p_lvl[0] ^ {g_lvl[LEVELS][INPUT_SIZE-2:0], c_in};
  assign c_out = g_lvl[LEVELS][INPUT_SIZE-1];

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
//   Ports:
//     clock, reset         rising-edge clock, async active-high reset
//     in_valid / in_ready  operand handshake (in_ready only in IDLE)
//     A, B, op             dividend, divisor, operation
//     out_valid/out_ready  result handshake (out_valid only in DONE)
//     Y                    quotient or remainder
//     busy                 high while an operation is in flight (EX stall)
//   Flow: IDLE -> CALC (N steps) -> FIX (signs, select) -> DONE -> IDLE.
//   Divide-by-zero and signed overflow bypass CALC/FIX and go to DONE with
//   the RISC-V defined result.
// ---------------------------------------------------------------------------
module seq_divider
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  div_op_t      op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic         busy
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN_VAL  = {1'b1, {(N-1){1'b0}}};

  div_state_t    state_q, state_d;
  div_op_t       op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          quo_neg_q, quo_neg_d;  // quotient must be negated in FIX
  logic          rem_neg_q, rem_neg_d;  // remainder takes the dividend's sign
  logic [N:0]    rem_q, rem_d;          // partial remainder, one guard bit
  logic [N-1:0]  quo_q, quo_d;          // |A| shifts out, quotient shifts in
  logic [N-1:0]  dvs_q, dvs_d;          // |B|
  logic [N-1:0]  y_q, y_d;

  // Restoring step: shift {rem,quo} left and trial-subtract |B|.
  logic [N:0] rem_shift;
  logic [N:0] trial_diff;
  logic       trial_ok;  // carry out == no borrow == difference non-negative

  assign rem_shift = {rem_q[N-1:0], quo_q[N-1]};

  sklansky_adder #(
    .INPUT_SIZE(N + 1)
  ) u_trial_sub (
    .a    (rem_shift),
    .b    (~{1'b0, dvs_q}),
    .c_in (1'b1),
    .sum  (trial_diff),
    .c_out(trial_ok)
  );

  always_comb begin
    logic a_neg;
    logic b_neg;
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    y_d       = y_q;
    a_neg     = 1'b0;
    b_neg     = 1'b0;

    unique case (state_q)
      DivIdle: begin
        if (in_valid) begin
          a_neg     = div_op_is_signed(op) & A[N-1];
          b_neg     = div_op_is_signed(op) & B[N-1];
          op_d      = op;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          quo_d     = a_neg ? -A : A;
          dvs_d     = b_neg ? -B : B;
          rem_d     = '0;
          cnt_d     = CNT_LAST;
          if (B == '0) begin
            y_d     = div_op_is_rem(op) ? A : '1;
            state_d = DivDone;
          end else if (div_op_is_signed(op) && (A == MIN_VAL) && (B == '1)) begin
            y_d     = div_op_is_rem(op) ? '0 : MIN_VAL;
            state_d = DivDone;
          end else begin
            state_d = DivCalc;
          end
        end
      end

      DivCalc: begin
        quo_d = {quo_q[N-2:0], trial_ok};
        rem_d = trial_ok ? trial_diff : rem_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DivFix;
        end
      end

      DivFix: begin
        if (div_op_is_rem(op_q)) begin
          y_d = rem_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        end else begin
          y_d = quo_neg_q ? -quo_q : quo_q;
        end
        state_d = DivDone;
      end

      DivDone: begin
        if (out_ready) begin
          state_d = DivIdle;
        end
      end

      default: state_d = DivIdle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DivIdle;
      op_q      <= Div;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      y_q       <= y_d;
    end
  end

  assign in_ready  = (state_q == DivIdle);
  assign busy      = (state_q != DivIdle);
  assign out_valid = (state_q == DivDone);
  assign Y         = y_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Scoreboard bench for seq_divider (N=64). The driver pushes the expected
//   result and latency from a plain-arithmetic reference model; a monitor
//   pops and compares on every rising edge of out_valid.
// ---------------------------------------------------------------------------
module tb_seq_divider;
  import alu_pkg::*;

  localparam int N   = 64;
  localparam int LAT = N + 2;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  div_op_t      op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic         busy;

  seq_divider #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] y;
    int           lat;
    int           acc_edge;
    logic [N-1:0] a;
    logic [N-1:0] b;
    div_op_t      o;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  logic prev_valid = 1'b0;
  logic rand_ready = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V division semantics from plain integer arithmetic.
  function automatic logic is_special(logic [N-1:0] a, logic [N-1:0] b, div_op_t o);
    logic sgn;
    sgn = (o == Div) || (o == Rem);
    return (b == '0) || (sgn && a == MIN_VAL && b == '1);
  endfunction

  function automatic logic [N-1:0] ref_result(logic [N-1:0] a, logic [N-1:0] b, div_op_t o);
    longint sa;
    longint sb;
    logic   want_rem;
    sa       = a;
    sb       = b;
    want_rem = (o == Rem) || (o == Remu);
    if (b == '0) return want_rem ? a : '1;
    if ((o == Div || o == Rem) && a == MIN_VAL && b == '1) return want_rem ? '0 : MIN_VAL;
    case (o)
      Div:     return N'(sa / sb);
      Rem:     return N'(sa % sb);
      Divu:    return a / b;
      default: return a % b;
    endcase
  endfunction

  // Monitor: compare once per result, on the cycle out_valid first appears.
  always @(negedge clock) begin
    if (out_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got Y=0x%016h, required no output", Y);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("Y %s 0x%0h/0x%0h", mon_e.o.name(), mon_e.a, mon_e.b), Y, mon_e.y);
        check($sformatf("latency %s 0x%0h/0x%0h", mon_e.o.name(), mon_e.a, mon_e.b),
              N'(cyc - mon_e.acc_edge), N'(mon_e.lat));
      end
    end
    prev_valid = out_valid;
  end

  always @(negedge clock) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Issue one operation; called at a negedge, returns one negedge after accept.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input div_op_t o);
    int   t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 400) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready=0, required 1 within 400 cycles");
      return;
    end
    A          = a;
    B          = b;
    op         = o;
    in_valid   = 1'b1;
    e.y        = ref_result(a, b, o);
    e.lat      = is_special(a, b, o) ? 1 : LAT;
    e.acc_edge = cyc;
    e.a        = a;
    e.b        = b;
    e.o        = o;
    sb_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || !in_ready) && t < 400) begin
      @(negedge clock);
      t++;
    end
    if (sb_q.size() != 0 || !in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           t;

    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A        = '0;
    B        = '0;
    op       = Div;

    #12;
    check("reset in_ready", N'(in_ready), N'(1));
    check("reset out_valid", N'(out_valid), N'(0));
    check("reset busy", N'(busy), N'(0));
    check("reset Y", Y, '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases, including every special-case path.
    issue(64'd100, 64'd7, Divu);
    issue(64'd100, 64'd7, Remu);
    issue(-64'sd7, 64'd2, Div);
    issue(-64'sd7, 64'd2, Rem);
    issue(64'd5, 64'd0, Div);
    issue(64'd5, 64'd0, Rem);
    issue(64'd5, 64'd0, Divu);
    issue(MIN_VAL, '1, Div);
    issue(MIN_VAL, '1, Rem);
    issue(MIN_VAL, '1, Divu);
    issue('1, 64'd1, Divu);
    issue('1, 64'd1, Div);
    issue(64'd0, 64'd5, Rem);
    issue(64'd7, -64'sd100, Rem);
    wait_drain();

    // Hold the result in DONE; a new request must be ignored throughout.
    out_ready = 1'b0;
    issue(64'd1000, -64'sd3, Div);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("hold reached_done", N'(out_valid), N'(1));
    for (int i = 0; i < 10; i++) begin
      A        = 64'd77;
      B        = 64'd1;
      op       = Divu;
      in_valid = 1'b1;
      check($sformatf("hold%0d Y", i), Y, -64'sd333);
      check($sformatf("hold%0d out_valid", i), N'(out_valid), N'(1));
      check($sformatf("hold%0d in_ready", i), N'(in_ready), N'(0));
      @(negedge clock);
    end
    out_ready = 1'b1;  // handshake with in_valid still high: must not accept
    @(negedge clock);
    in_valid = 1'b0;
    check("bubble in_ready", N'(in_ready), N'(1));
    @(negedge clock);
    check("bubble not_accepted", N'(busy), N'(0));
    wait_drain();

    // Reset in the middle of CALC aborts with no result presented.
    issue(64'd1000, 64'd3, Divu);
    repeat (19) @(negedge clock);
    check("abort in_calc", N'(busy), N'(1));
    #2 reset = 1'b1;
    sb_q.delete();
    #1;
    check("abort in_ready", N'(in_ready), N'(1));
    check("abort busy", N'(busy), N'(0));
    check("abort out_valid", N'(out_valid), N'(0));
    check("abort Y", Y, '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clock);
    issue(-64'sd100, 64'd7, Div);
    wait_drain();

    // Randomised operands with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = N'($urandom_range(1, 15));
        2:       rb = '1;
        3:       rb = N'($urandom);
        4:       rb = ra;
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) ra = MIN_VAL;
      issue(ra, rb, div_op_t'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
